// File: rtl/wb_timer.sv
// wb_timer: Wishbone B3 classic slave, prescaled 32-bit down-counter with level IRQ.
// Define WB_TIMER_PWM_EN to add the COMPARE register and the registered PWM output.
module wb_timer #(
   parameter int unsigned PRESCALE_W = 16,
   parameter logic [31:0] RESET_LOAD = 32'h0000_0000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        wb_rty_o,
   output logic        irq_o,
   output logic        pwm_o
);

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_PRE    = 3'd1;
   localparam logic [2:0] A_LOAD   = 3'd2;
   localparam logic [2:0] A_COUNT  = 3'd3;
   localparam logic [2:0] A_STATUS = 3'd4;
   localparam logic [2:0] A_CMP    = 3'd5;

   logic [2:0]            ctrl_q, ctrl_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
   logic [31:0]           load_q, load_d;
   logic [31:0]           count_q, count_d;
   logic                  expired_q, expired_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [31:0]           dat_q, dat_d;
   logic                  irq_q, irq_d;

   logic [2:0]  adr;
   logic        req, mapped, wr;
   logic        wr_ctrl, wr_pre, wr_load, wr_count, wr_status;
   logic [31:0] wmask;
   logic [2:0]  ctrl_new;
   logic        tick, tick_ok, expire;
   logic [31:0] rdata;
   logic        unused_adr;

   assign adr        = wb_adr_i[4:2];
   assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};
   assign req        = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
   assign mapped     = ~(adr[2] & adr[1]);
   assign wr         = req & mapped & wb_we_i;
   assign wr_ctrl    = wr & (adr == A_CTRL);
   assign wr_pre     = wr & (adr == A_PRE);
   assign wr_load    = wr & (adr == A_LOAD);
   assign wr_count   = wr & (adr == A_COUNT);
   assign wr_status  = wr & (adr == A_STATUS);
   assign wmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

   // A CTRL write overrides anything the counter would do to CTRL this cycle.
   assign ctrl_new = wr_ctrl ? ((ctrl_q & ~wmask[2:0]) | (wb_dat_i[2:0] & wmask[2:0])) : ctrl_q;

   assign tick    = ctrl_q[0] && (pcnt_q == prescale_q);
   assign tick_ok = tick && !wr_count && ctrl_new[0];
   assign expire  = tick_ok && (count_q == 32'd0);

`ifdef WB_TIMER_PWM_EN
   logic        wr_cmp;
   logic [31:0] compare_q, compare_d;
   logic        pwm_q, pwm_d;

   assign wr_cmp    = wr & (adr == A_CMP);
   assign compare_d = wr_cmp ? ((compare_q & ~wmask) | (wb_dat_i & wmask)) : compare_q;
   assign pwm_d     = ctrl_q[0] && (count_q < compare_q);
   assign pwm_o     = pwm_q;

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         compare_q <= '0;
         pwm_q     <= 1'b0;
      end else begin
         compare_q <= compare_d;
         pwm_q     <= pwm_d;
      end
   end
`else
   assign pwm_o = 1'b0;
`endif

   always_comb begin
      rdata = '0;
      case (adr)
         A_CTRL:   rdata = {29'd0, ctrl_q};
         A_PRE:    rdata = 32'(prescale_q);
         A_LOAD:   rdata = load_q;
         A_COUNT:  rdata = count_q;
         A_STATUS: rdata = {31'd0, expired_q};
`ifdef WB_TIMER_PWM_EN
         A_CMP:    rdata = compare_q;
`endif
         default:  rdata = '0;
      endcase
   end

   always_comb begin
      ctrl_d     = ctrl_new;
      prescale_d = wr_pre ? ((prescale_q & ~wmask[PRESCALE_W-1:0]) |
                             (wb_dat_i[PRESCALE_W-1:0] & wmask[PRESCALE_W-1:0])) : prescale_q;
      load_d     = wr_load ? ((load_q & ~wmask) | (wb_dat_i & wmask)) : load_q;
      pcnt_d     = pcnt_q;
      count_d    = count_q;
      expired_d  = expired_q;

      // Prescaler wraps naturally past 2^W-1 if PRESCALE was lowered below it.
      if (ctrl_q[0])
         pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);

      if (tick_ok) begin
         if (count_q != 32'd0)
            count_d = count_q - 32'd1;
         else if (ctrl_new[2])
            count_d = load_q;
         else if (!wr_ctrl)
            ctrl_d[0] = 1'b0;
      end

      if (wr_count) begin
         count_d = (count_q & ~wmask) | (wb_dat_i & wmask);
         pcnt_d  = '0;
      end

      if (wr_status && wb_sel_i[0] && wb_dat_i[0])
         expired_d = 1'b0;
      if (expire)
         expired_d = 1'b1;

      ack_d = req & mapped;
      err_d = req & ~mapped;
      dat_d = (req && mapped && !wb_we_i) ? rdata : '0;
      irq_d = expired_q & ctrl_q[1];
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         pcnt_q     <= '0;
         load_q     <= RESET_LOAD;
         count_q    <= RESET_LOAD;
         expired_q  <= 1'b0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         dat_q      <= '0;
         irq_q      <= 1'b0;
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         pcnt_q     <= pcnt_d;
         load_q     <= load_d;
         count_q    <= count_d;
         expired_q  <= expired_d;
         ack_q      <= ack_d;
         err_q      <= err_d;
         dat_q      <= dat_d;
         irq_q      <= irq_d;
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = 1'b0;
   assign irq_o    = irq_q;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: directed bus/collision steps plus randomized
// one-shot and auto-reload runs predicted from the timing rules with plain arithmetic.
module tb_wb_timer;

   localparam logic [2:0] A_CTRL = 3'd0, A_PRE = 3'd1, A_LOAD = 3'd2, A_COUNT = 3'd3,
                          A_STATUS = 3'd4, A_CMP = 3'd5;

   logic        clk = 1'b0, rst = 1'b1;
   logic [31:0] adr = '0, dat_w = '0;
   logic [3:0]  sel = '0;
   logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
   logic [31:0] dat_r;
   logic        ack, err, rty, irq, pwm;

   int edge_n = 0;
   int checks = 0, passes = 0, fails = 0;

   wb_timer dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_sel_i(sel),
      .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_dat_o(dat_r), .wb_ack_o(ack),
      .wb_err_o(err), .wb_rty_o(rty), .irq_o(irq), .pwm_o(pwm)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One bus transfer; returns data, response flags, the response edge and its latency.
   task automatic xfer(input logic w, input logic [2:0] off, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic a, output logic e,
                       output int at, output int lat);
      int st;
      st = edge_n;
      cyc = 1'b1; stb = 1'b1; we = w; adr = {27'd0, off, 2'b00}; dat_w = d; sel = s;
      rd = '0; a = 1'b0; e = 1'b0; at = -1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ack || err) begin
            rd = dat_r; a = ack; e = err; at = edge_n;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = '0;
      lat = at - st;
      if (at < 0) begin
         checks++; fails++;
         $error("FAIL bus_timeout: observed no response expected ack or err");
      end
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d, output int at);
      logic [31:0] v; logic a, e; int lat;
      xfer(1'b1, off, d, 4'hF, v, a, e, at, lat);
      check("wr_ack", {31'd0, a}, 32'd1);
   endtask

   task automatic rd(input logic [2:0] off, output logic [31:0] v, output int at);
      logic a, e; int lat;
      xfer(1'b0, off, '0, 4'h0, v, a, e, at, lat);
      check("rd_ack", {31'd0, a}, 32'd1);
   endtask

   // Returns at edge T-1 (+1) so the next transfer is requested on edge T.
   task automatic wait_to(input int t);
      while (edge_n < t - 1) begin @(posedge clk); #1; end
   endtask

   task automatic expect_rise(input int t, input string tag);
      int r;
      r = -1;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (irq) begin r = edge_n; break; end
      end
      check(tag, 32'(r), 32'(t));
   endtask

   // One-shot: expiry lands (C+1)*(P+1) edges after the enabling write.
   task automatic oneshot_run(input int p, input int c, input int d);
      int e0, at, m, expv, ti; logic [31:0] v;
      wr(A_CTRL, 32'd0, at); wr(A_STATUS, 32'd1, at);
      wr(A_PRE, 32'(p), at); wr(A_COUNT, 32'(c), at);
      wr(A_CTRL, 32'd3, e0);
      repeat (d) begin @(posedge clk); #1; end
      rd(A_COUNT, v, at);
      m = at - 1 - e0;
      expv = c - m / (p + 1);
      if (expv < 0) expv = 0;
      check("os_count", v, 32'(expv));
      ti = e0 + (c + 1) * (p + 1) + 1;
      if (edge_n < ti) expect_rise(ti, "os_irq_rise");
      else check("os_irq_level", {31'd0, irq}, 32'd1);
      rd(A_CTRL, v, at);   check("os_ctrl", v, 32'd2);
      rd(A_STATUS, v, at); check("os_status", v, 32'd1);
   endtask

   task automatic autoreload_run(input int p, input int l);
      int e0, at, r, w, period;
      period = (l + 1) * (p + 1);
      wr(A_CTRL, 32'd0, at); wr(A_STATUS, 32'd1, at);
      wr(A_PRE, 32'(p), at); wr(A_LOAD, 32'(l), at); wr(A_COUNT, 32'(l), at);
      wr(A_CTRL, 32'd7, e0);
      expect_rise(e0 + period + 1, "ar_rise1");
      r = edge_n;
      wr(A_STATUS, 32'd1, w);
      check("ar_clr_edge", 32'(w), 32'(r + 1));
      check("ar_irq_hold", {31'd0, irq}, 32'd1);
      @(posedge clk); #1;
      check("ar_irq_drop", {31'd0, irq}, 32'd0);
      expect_rise(r + period, "ar_rise2");
      wr(A_CTRL, 32'd0, at);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v; logic a, e; int at, lat, e0, t, r, acks, hi;
`ifdef WB_TIMER_PWM_EN
      localparam logic [31:0] EXP_CMP = 32'd3, EXP_HI = 32'd9;
`else
      localparam logic [31:0] EXP_CMP = 32'd0, EXP_HI = 32'd0;
`endif

      // Reset
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", {31'd0, ack}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_dat", dat_r, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      check("rst_pwm", {31'd0, pwm}, 32'd0);
      check("rst_rty", {31'd0, rty}, 32'd0);
      rst = 1'b0;
      for (int o = 0; o < 6; o++) begin
         xfer(1'b0, 3'(o), '0, 4'h0, v, a, e, at, lat);
         check("rst_val", v, 32'd0);
         check("rst_rd_ack", {31'd0, a}, 32'd1);
         check("rst_rd_err", {31'd0, e}, 32'd0);
         check("rst_latency", 32'(lat), (o == 0) ? 32'd1 : 32'd2);
      end

      // Directed one-shot
      wr(A_PRE, 32'd0, at); wr(A_LOAD, 32'd2, at); wr(A_COUNT, 32'd2, at);
      wr(A_CTRL, 32'd3, e0);
      expect_rise(e0 + 4, "os_dir_rise");
      rd(A_CTRL, v, at);  check("os_dir_ctrl", v, 32'd2);
      rd(A_COUNT, v, at); check("os_dir_count", v, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      rd(A_COUNT, v, at); check("os_dir_count_hold", v, 32'd0);

      // Auto-reload: directed then randomized
      autoreload_run(3, 4);
      for (int i = 0; i < 4; i++)
         autoreload_run(int'($urandom_range(1, 3)), int'($urandom_range(1, 5)));

      for (int i = 0; i < 8; i++)
         oneshot_run(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)), int'($urandom_range(0, 10)));

      // COUNT write on the tick-at-zero edge
      wr(A_CTRL, 32'd0, at); wr(A_STATUS, 32'd1, at);
      wr(A_PRE, 32'd0, at); wr(A_COUNT, 32'd3, at);
      wr(A_CTRL, 32'd3, e0);
      t = e0 + 4;
      wait_to(t);
      wr(A_COUNT, 32'd100, at);
      check("coll_cnt_edge", 32'(at), 32'(t));
      rd(A_STATUS, v, at); check("coll_cnt_status", v, 32'd0);
      rd(A_COUNT, v, at);  check("coll_cnt_value", v, 32'(100 - (at - 1 - t)));
      rd(A_CTRL, v, at);   check("coll_cnt_ctrl", v, 32'd3);

      // STATUS clear on the expiry edge
      wr(A_CTRL, 32'd0, at); wr(A_STATUS, 32'd1, at);
      wr(A_COUNT, 32'd3, at);
      wr(A_CTRL, 32'd3, e0);
      t = e0 + 4;
      wait_to(t);
      wr(A_STATUS, 32'd1, at);
      check("coll_clr_edge", 32'(at), 32'(t));
      rd(A_STATUS, v, at); check("coll_clr_status", v, 32'd1);

      // Bus edge cases
      wr(A_CTRL, 32'd0, at);
      wr(A_LOAD, 32'h1234_5678, at);
      xfer(1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, v, a, e, at, lat);
      check("unmap_err", {31'd0, e}, 32'd1);
      check("unmap_ack", {31'd0, a}, 32'd0);
      check("unmap_dat", v, 32'd0);
      @(posedge clk); #1;
      check("unmap_err_pulse", {31'd0, err}, 32'd0);
      xfer(1'b0, 3'd7, '0, 4'h0, v, a, e, at, lat);
      check("unmap7_err", {31'd0, e}, 32'd1);
      rd(A_LOAD, v, at); check("unmap_nochange", v, 32'h1234_5678);

      wr(A_LOAD, 32'd0, at);
      xfer(1'b1, A_LOAD, 32'hAABB_CCDD, 4'b0010, v, a, e, at, lat);
      rd(A_LOAD, v, at); check("sel_lane1", v, 32'h0000_CC00);
      xfer(1'b1, A_LOAD, 32'hFFFF_FFFF, 4'b0000, v, a, e, at, lat);
      check("sel0_ack", {31'd0, a}, 32'd1);
      rd(A_LOAD, v, at); check("sel0_nochange", v, 32'h0000_CC00);

      cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = {27'd0, A_LOAD, 2'b00}; dat_w = '1; sel = 4'hF;
      #2 stb = 1'b0;
      acks = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (ack || err) acks++;
      end
      cyc = 1'b0; we = 1'b0; sel = '0;
      check("stb_drop_resp", 32'(acks), 32'd0);
      rd(A_LOAD, v, at); check("stb_drop_nochange", v, 32'h0000_CC00);

      // PWM / COMPARE
      wr(A_CTRL, 32'd0, at); wr(A_PRE, 32'd0, at);
      wr(A_LOAD, 32'd9, at); wr(A_COUNT, 32'd9, at);
      xfer(1'b1, A_CMP, 32'd3, 4'hF, v, a, e, at, lat);
      check("cmp_wr_ack", {31'd0, a}, 32'd1);
      check("cmp_wr_err", {31'd0, e}, 32'd0);
      wr(A_CTRL, 32'd5, at);
      repeat (12) @(posedge clk);
      #1;
      hi = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (pwm) hi++;
      end
      check("pwm_high_30", 32'(hi), EXP_HI);
      rd(A_CMP, v, at); check("cmp_rd", v, EXP_CMP);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
